// File: rtl/mr1_mem_arbiter_if.sv
// Bundle of MR1 fetch/data request-response ports and the shared memory bus.
// The arbiter connects through the slave modport; the driving environment uses master.
interface mr1_mem_arbiter_if;
   logic        instr_req_valid;
   logic        instr_req_ready;
   logic [31:0] instr_req_addr;
   logic        instr_rsp_valid;
   logic [31:0] instr_rsp_data;
   logic        data_req_valid;
   logic        data_req_ready;
   logic        data_req_wr;
   logic [31:0] data_req_addr;
   logic [1:0]  data_req_size;
   logic [31:0] data_req_data;
   logic        data_rsp_valid;
   logic [31:0] data_rsp_data;
   logic        mem_req_valid;
   logic        mem_req_ready;
   logic        mem_req_wr;
   logic [31:0] mem_req_addr;
   logic [1:0]  mem_req_size;
   logic [31:0] mem_req_data;
   logic        mem_rsp_valid;
   logic [31:0] mem_rsp_data;
   logic        err_rsp_orphan;

   modport slave (
      input  instr_req_valid, instr_req_addr,
      input  data_req_valid, data_req_wr, data_req_addr, data_req_size, data_req_data,
      input  mem_req_ready, mem_rsp_valid, mem_rsp_data,
      output instr_req_ready, instr_rsp_valid, instr_rsp_data,
      output data_req_ready, data_rsp_valid, data_rsp_data,
      output mem_req_valid, mem_req_wr, mem_req_addr, mem_req_size, mem_req_data,
      output err_rsp_orphan
   );

   modport master (
      output instr_req_valid, instr_req_addr,
      output data_req_valid, data_req_wr, data_req_addr, data_req_size, data_req_data,
      output mem_req_ready, mem_rsp_valid, mem_rsp_data,
      input  instr_req_ready, instr_rsp_valid, instr_rsp_data,
      input  data_req_ready, data_rsp_valid, data_rsp_data,
      input  mem_req_valid, mem_req_wr, mem_req_addr, mem_req_size, mem_req_data,
      input  err_rsp_orphan
   );
endinterface

// File: rtl/mr1_mem_arbiter.sv
// Two-port (fetch/data) arbiter onto one memory bus with request lock, starvation
// guard and an owner FIFO that steers in-order read responses back to their issuer.
module mr1_mem_arbiter #(
   parameter int unsigned MAX_OUTSTANDING = 2,
   parameter int unsigned DATA_PRIORITY   = 1,
   parameter int unsigned STARVE_LIMIT    = 4
) (
   input logic              clk,
   input logic              reset_n,
   mr1_mem_arbiter_if.slave bus
);

   localparam int unsigned   CW        = $clog2(MAX_OUTSTANDING + 1);
   localparam int unsigned   SW        = $clog2(STARVE_LIMIT + 1);
   localparam int unsigned   FD        = 1 << CW;
   localparam logic [CW-1:0] LP_MAX    = CW'(MAX_OUTSTANDING);
   localparam logic [CW-1:0] LP_LAST   = CW'(MAX_OUTSTANDING - 1);
   localparam logic [SW-1:0] LP_STARVE = SW'(STARVE_LIMIT);

   logic [FD-1:0] r_fifo;
   logic [CW-1:0] r_wptr;
   logic [CW-1:0] r_rptr;
   logic [CW-1:0] r_count;
   logic          r_lock;
   logic          r_lock_own;
   logic          r_lock_wr;
   logic [31:0]   r_lock_addr;
   logic [1:0]    r_lock_size;
   logic [31:0]   r_lock_data;
   logic [SW-1:0] r_starve_i;
   logic [SW-1:0] r_starve_d;

   logic        w_room;
   logic        w_elig_i;
   logic        w_elig_d;
   logic        w_pref_d;
   logic        w_valid;
   logic        w_own;
   logic        w_wr;
   logic [31:0] w_addr;
   logic [1:0]  w_size;
   logic [31:0] w_data;
   logic        w_accept;
   logic        w_push;
   logic        w_pop;
   logic        w_orphan;
   logic        w_head;

   function automatic logic [CW-1:0] f_inc(input logic [CW-1:0] p);
      return (p == LP_LAST) ? '0 : p + 1'b1;
   endfunction

   always_comb begin
      // Room is judged on the registered count, so a same-cycle pop cannot unblock a read.
      w_room   = (r_count < LP_MAX);
      w_elig_i = bus.instr_req_valid && w_room;
      w_elig_d = bus.data_req_valid && (bus.data_req_wr || w_room);
      if (r_starve_i == LP_STARVE)      w_pref_d = 1'b0;
      else if (r_starve_d == LP_STARVE) w_pref_d = 1'b1;
      else                              w_pref_d = (DATA_PRIORITY != 0);

      w_valid = w_elig_i || w_elig_d;
      w_own   = w_elig_d && (!w_elig_i || w_pref_d);
      if (w_own) begin
         w_wr   = bus.data_req_wr;
         w_addr = bus.data_req_addr;
         w_size = bus.data_req_size;
         w_data = bus.data_req_data;
      end else begin
         w_wr   = 1'b0;
         w_addr = bus.instr_req_addr;
         w_size = 2'd2;
         w_data = 32'd0;
      end
      if (r_lock) begin
         w_valid = 1'b1;
         w_own   = r_lock_own;
         w_wr    = r_lock_wr;
         w_addr  = r_lock_addr;
         w_size  = r_lock_size;
         w_data  = r_lock_data;
      end

      w_accept = w_valid && bus.mem_req_ready;
      w_push   = w_accept && !w_wr;
      w_head   = r_fifo[r_rptr];
      w_pop    = bus.mem_rsp_valid && (r_count != '0);
      w_orphan = bus.mem_rsp_valid && (r_count == '0);
   end

   always_comb begin
      bus.mem_req_valid   = 1'b0;
      bus.mem_req_wr      = 1'b0;
      bus.mem_req_addr    = 32'd0;
      bus.mem_req_size    = 2'd0;
      bus.mem_req_data    = 32'd0;
      bus.instr_req_ready = 1'b0;
      bus.data_req_ready  = 1'b0;
      bus.instr_rsp_valid = 1'b0;
      bus.instr_rsp_data  = 32'd0;
      bus.data_rsp_valid  = 1'b0;
      bus.data_rsp_data   = 32'd0;
      bus.err_rsp_orphan  = 1'b0;
      if (reset_n) begin
         bus.mem_req_valid   = w_valid;
         bus.mem_req_wr      = w_wr;
         bus.mem_req_addr    = w_addr;
         bus.mem_req_size    = w_size;
         bus.mem_req_data    = w_data;
         bus.instr_req_ready = w_valid && !w_own && bus.mem_req_ready;
         bus.data_req_ready  = w_valid && w_own && bus.mem_req_ready;
         bus.instr_rsp_valid = w_pop && !w_head;
         bus.data_rsp_valid  = w_pop && w_head;
         bus.instr_rsp_data  = bus.mem_rsp_data;
         bus.data_rsp_data   = bus.mem_rsp_data;
         bus.err_rsp_orphan  = w_orphan;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         r_fifo      <= '0;
         r_wptr      <= '0;
         r_rptr      <= '0;
         r_count     <= '0;
         r_lock      <= 1'b0;
         r_lock_own  <= 1'b0;
         r_lock_wr   <= 1'b0;
         r_lock_addr <= 32'd0;
         r_lock_size <= 2'd0;
         r_lock_data <= 32'd0;
         r_starve_i  <= '0;
         r_starve_d  <= '0;
      end else begin
         if (w_push) begin
            r_fifo[r_wptr] <= w_own;
            r_wptr         <= f_inc(r_wptr);
         end
         if (w_pop) r_rptr <= f_inc(r_rptr);
         if (w_push && !w_pop)      r_count <= r_count + 1'b1;
         else if (!w_push && w_pop) r_count <= r_count - 1'b1;

         if (w_valid && !bus.mem_req_ready) begin
            r_lock      <= 1'b1;
            r_lock_own  <= w_own;
            r_lock_wr   <= w_wr;
            r_lock_addr <= w_addr;
            r_lock_size <= w_size;
            r_lock_data <= w_data;
         end else if (w_accept) begin
            r_lock <= 1'b0;
         end

         if (!bus.instr_req_valid || (w_accept && !w_own))
            r_starve_i <= '0;
         else if (w_accept && w_own && (r_starve_i != LP_STARVE))
            r_starve_i <= r_starve_i + 1'b1;

         if (!bus.data_req_valid || (w_accept && w_own))
            r_starve_d <= '0;
         else if (w_accept && !w_own && (r_starve_d != LP_STARVE))
            r_starve_d <= r_starve_d + 1'b1;
      end
   end

endmodule

// File: tb/tb_mr1_mem_arbiter.sv
// Directed bench for mr1_mem_arbiter: priority, lock, FIFO full, starvation, orphan, reset.
module tb_mr1_mem_arbiter;

   logic clk;
   logic reset_n;
   int   n_checks;
   int   n_errors;

   mr1_mem_arbiter_if u_if ();

   mr1_mem_arbiter #(
      .MAX_OUTSTANDING (2),
      .DATA_PRIORITY   (1),
      .STARVE_LIMIT    (4)
   ) u_dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (u_if)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic idle();
      u_if.instr_req_valid = 1'b0;
      u_if.instr_req_addr  = 32'd0;
      u_if.data_req_valid  = 1'b0;
      u_if.data_req_wr     = 1'b0;
      u_if.data_req_addr   = 32'd0;
      u_if.data_req_size   = 2'd0;
      u_if.data_req_data   = 32'd0;
      u_if.mem_req_ready   = 1'b0;
      u_if.mem_rsp_valid   = 1'b0;
      u_if.mem_rsp_data    = 32'd0;
   endtask

   // Inputs change at negedge; outputs are checked 1 time unit later, before the posedge.
   task automatic tick();
      @(negedge clk);
   endtask

   initial begin
      n_checks = 0;
      n_errors = 0;
      idle();
      reset_n = 1'b0;
      u_if.instr_req_valid = 1'b1;
      u_if.mem_req_ready   = 1'b1;
      u_if.mem_rsp_valid   = 1'b1;
      tick();
      #1;
      chk("rst_mem_valid", u_if.mem_req_valid, 0);
      chk("rst_instr_ready", u_if.instr_req_ready, 0);
      chk("rst_instr_rsp", u_if.instr_rsp_valid, 0);
      chk("rst_orphan", u_if.err_rsp_orphan, 0);
      tick();
      reset_n = 1'b1;
      idle();
      tick();

      // 1: simultaneous reads, data first, responses routed D then I
      u_if.instr_req_valid = 1'b1;
      u_if.instr_req_addr  = 32'h1000;
      u_if.data_req_valid  = 1'b1;
      u_if.data_req_addr   = 32'h2000;
      u_if.data_req_size   = 2'd2;
      u_if.mem_req_ready   = 1'b1;
      #1;
      chk("t1_c0_addr", u_if.mem_req_addr, 32'h2000);
      chk("t1_c0_dready", u_if.data_req_ready, 1);
      chk("t1_c0_iready", u_if.instr_req_ready, 0);
      tick();
      u_if.data_req_valid = 1'b0;
      #1;
      chk("t1_c1_addr", u_if.mem_req_addr, 32'h1000);
      chk("t1_c1_size", u_if.mem_req_size, 2);
      chk("t1_c1_wr", u_if.mem_req_wr, 0);
      chk("t1_c1_iready", u_if.instr_req_ready, 1);
      tick();
      u_if.instr_req_valid = 1'b0;
      u_if.mem_rsp_valid   = 1'b1;
      u_if.mem_rsp_data    = 32'hD0D0;
      #1;
      chk("t1_r0_dvalid", u_if.data_rsp_valid, 1);
      chk("t1_r0_ivalid", u_if.instr_rsp_valid, 0);
      chk("t1_r0_ddata", u_if.data_rsp_data, 32'hD0D0);
      tick();
      u_if.mem_rsp_data = 32'h1111;
      #1;
      chk("t1_r1_ivalid", u_if.instr_rsp_valid, 1);
      chk("t1_r1_dvalid", u_if.data_rsp_valid, 0);
      chk("t1_r1_idata", u_if.instr_rsp_data, 32'h1111);
      tick();
      idle();

      // 2: stalled store held by the lock even if the source fields change
      u_if.data_req_valid = 1'b1;
      u_if.data_req_wr    = 1'b1;
      u_if.data_req_addr  = 32'h100;
      u_if.data_req_size  = 2'd0;
      u_if.data_req_data  = 32'hAB;
      for (int k = 0; k < 4; k++) begin
         if (k == 1) begin
            u_if.data_req_addr = 32'h999;
            u_if.data_req_data = 32'h0;
            u_if.data_req_size = 2'd2;
         end
         u_if.mem_req_ready = (k == 3);
         #1;
         chk("t2_valid", u_if.mem_req_valid, 1);
         chk("t2_addr", u_if.mem_req_addr, 32'h100);
         chk("t2_data", u_if.mem_req_data, 32'hAB);
         chk("t2_size", u_if.mem_req_size, 0);
         chk("t2_wr", u_if.mem_req_wr, 1);
         chk("t2_dready", u_if.data_req_ready, (k == 3) ? 1 : 0);
         tick();
      end
      idle();
      #1;
      chk("t2_idle_valid", u_if.mem_req_valid, 0);
      tick();

      // 5: orphan response (store above left the FIFO empty)
      u_if.mem_rsp_valid = 1'b1;
      u_if.mem_rsp_data  = 32'hDEAD;
      #1;
      chk("t5_orphan", u_if.err_rsp_orphan, 1);
      chk("t5_ivalid", u_if.instr_rsp_valid, 0);
      chk("t5_dvalid", u_if.data_rsp_valid, 0);
      tick();
      idle();
      #1;
      chk("t5_orphan_clr", u_if.err_rsp_orphan, 0);
      tick();

      // 3: third read blocked by full FIFO, even during a pop
      u_if.instr_req_valid = 1'b1;
      u_if.instr_req_addr  = 32'h3000;
      u_if.mem_req_ready   = 1'b1;
      #1;
      chk("t3_a0_ready", u_if.instr_req_ready, 1);
      tick();
      u_if.instr_req_addr = 32'h3004;
      #1;
      chk("t3_a1_ready", u_if.instr_req_ready, 1);
      tick();
      u_if.instr_req_addr = 32'h3008;
      #1;
      chk("t3_full_ready", u_if.instr_req_ready, 0);
      chk("t3_full_valid", u_if.mem_req_valid, 0);
      tick();
      u_if.mem_rsp_valid = 1'b1;
      u_if.mem_rsp_data  = 32'hA0;
      #1;
      chk("t3_pop_ready", u_if.instr_req_ready, 0);
      chk("t3_pop_ivalid", u_if.instr_rsp_valid, 1);
      tick();
      u_if.mem_rsp_valid = 1'b0;
      #1;
      chk("t3_after_ready", u_if.instr_req_ready, 1);
      chk("t3_after_addr", u_if.mem_req_addr, 32'h3008);
      tick();
      u_if.instr_req_valid = 1'b0;
      u_if.mem_rsp_valid   = 1'b1;
      for (int k = 0; k < 2; k++) begin
         #1;
         chk("t3_drain_ivalid", u_if.instr_rsp_valid, 1);
         tick();
      end
      idle();
      #1;
      chk("t3_drained_orphan", u_if.err_rsp_orphan, 0);
      tick();

      // 4: data stores win 4 times, then starved instr is forced through
      u_if.data_req_valid  = 1'b1;
      u_if.data_req_wr     = 1'b1;
      u_if.data_req_addr   = 32'h4000;
      u_if.instr_req_valid = 1'b1;
      u_if.instr_req_addr  = 32'h5000;
      u_if.mem_req_ready   = 1'b1;
      for (int k = 0; k < 4; k++) begin
         #1;
         chk("t4_dready", u_if.data_req_ready, 1);
         chk("t4_iready", u_if.instr_req_ready, 0);
         tick();
      end
      #1;
      chk("t4_forced_iready", u_if.instr_req_ready, 1);
      chk("t4_forced_dready", u_if.data_req_ready, 0);
      chk("t4_forced_addr", u_if.mem_req_addr, 32'h5000);
      tick();
      #1;
      chk("t4_back_dready", u_if.data_req_ready, 1);
      tick();
      idle();
      u_if.mem_rsp_valid = 1'b1;
      #1;
      chk("t4_rsp_ivalid", u_if.instr_rsp_valid, 1);
      tick();
      idle();
      tick();

      // 6: reset with two reads in flight discards their owners
      u_if.instr_req_valid = 1'b1;
      u_if.instr_req_addr  = 32'h6000;
      u_if.mem_req_ready   = 1'b1;
      tick();
      tick();
      reset_n = 1'b0;
      u_if.mem_rsp_valid = 1'b1;
      #1;
      chk("t6_rst_valid", u_if.mem_req_valid, 0);
      chk("t6_rst_iready", u_if.instr_req_ready, 0);
      chk("t6_rst_ivalid", u_if.instr_rsp_valid, 0);
      chk("t6_rst_orphan", u_if.err_rsp_orphan, 0);
      tick();
      reset_n = 1'b1;
      idle();
      u_if.mem_rsp_valid = 1'b1;
      u_if.mem_rsp_data  = 32'h5555;
      #1;
      chk("t6_orphan", u_if.err_rsp_orphan, 1);
      chk("t6_ivalid", u_if.instr_rsp_valid, 0);
      chk("t6_dvalid", u_if.data_rsp_valid, 0);
      tick();
      idle();
      tick();

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
